// File: rtl/tff_sched_pkg.sv
// Shared types and helpers for the T-flip-flop counter scheduler.
// Toggle helpers work on MAXW bits; callers cast results down to their own width.
package tff_sched_pkg;

  localparam int unsigned DEF_W = 4;
  localparam int unsigned MAXW  = 32;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Up step toggles bit i when every lower bit is 1 (bit 0 always toggles).
  function automatic logic [MAXW-1:0] up_toggle(input logic [MAXW-1:0] q);
    logic [MAXW-1:0] t;
    logic            carry;
    t     = '0;
    carry = 1'b1;
    for (int i = 0; i < int'(MAXW); i++) begin
      t[i]  = carry;
      carry = carry & q[i];
    end
    return t;
  endfunction

  // Down step toggles bit i when every lower bit is 0 (bit 0 always toggles).
  function automatic logic [MAXW-1:0] down_toggle(input logic [MAXW-1:0] q);
    logic [MAXW-1:0] t;
    logic            borrow;
    t      = '0;
    borrow = 1'b1;
    for (int i = 0; i < int'(MAXW); i++) begin
      t[i]   = borrow;
      borrow = borrow & ~q[i];
    end
    return t;
  endfunction

  // Effective modulus: a programmed 0 means the full 2^w range.
  function automatic logic [MAXW:0] eff_mod(input logic [MAXW-1:0] m,
                                            input int unsigned    w);
    logic [MAXW:0] r;
    if (m == '0) begin
      r = (MAXW+1)'(1) << w;
    end else begin
      r = {1'b0, m};
    end
    return r;
  endfunction

endpackage

// File: rtl/tff_bank.sv
// W-bit register built from T flip-flops: each bit flips when its toggle input is high.
// Asynchronous active-high reset loads RST_VAL.
module tff_bank
  import tff_sched_pkg::*;
#(
  parameter int unsigned     W       = DEF_W,
  parameter logic [W-1:0]    RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] t,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= RST_VAL;
    end else begin
      q <= q ^ t;
    end
  end

endmodule

// File: rtl/tff_count_sched.sv
// Modulo up/down counter realised by driving only the toggle inputs of a TFF bank.
// Optional one-shot mode (stop on wrap) is enabled by defining TFF_SCHED_AUTOSTOP_EN.
module tff_count_sched
  import tff_sched_pkg::*;
#(
  parameter int unsigned  W       = DEF_W,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic         stop,
  input  logic         dir,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic [W-1:0] modulus,
  output logic [W-1:0] q,
  output logic         tc,
  output logic         busy,
  output state_t       state_dbg
);

  state_t       state;
  state_t       state_nx;
  logic [W-1:0] t;
  logic [W-1:0] up_t;
  logic [W-1:0] dn_t;
  logic [W:0]   meff;
  logic [W:0]   meff_m1;
  logic         wrap;

  assign meff      = (W+1)'(eff_mod(MAXW'(modulus), W));
  assign meff_m1   = meff - (W+1)'(1);
  assign up_t      = W'(up_toggle(MAXW'(q)));
  assign dn_t      = W'(down_toggle(MAXW'(q)));
  assign state_dbg = state;

  // Toggle vector and next state; priority is load > stop > start > count.
  always_comb begin
    t        = '0;
    state_nx = state;
    wrap     = 1'b0;
    if (load) begin
      t        = q ^ load_val;
      state_nx = IDLE;
    end else if (state == IDLE) begin
      if (start && !stop) begin
        state_nx = RUN;
      end
    end else if (stop) begin
      state_nx = IDLE;
    end else begin
      if (dir) begin
        // Anything at or above the top value (including out-of-range loads) wraps to 0.
        if ({1'b0, q} >= meff_m1) begin
          t    = q;
          wrap = 1'b1;
        end else begin
          t = up_t;
        end
      end else begin
        if (q == '0) begin
          t    = q ^ meff_m1[W-1:0];
          wrap = 1'b1;
        end else begin
          t = dn_t;
        end
      end
`ifdef TFF_SCHED_AUTOSTOP_EN
      if (wrap) begin
        state_nx = IDLE;
      end
`endif
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      tc    <= 1'b0;
      busy  <= 1'b0;
    end else begin
      state <= state_nx;
      tc    <= wrap;
      busy  <= (state_nx == RUN);
    end
  end

  tff_bank #(
    .W       (W),
    .RST_VAL (RST_VAL)
  ) u_bank (
    .clk (clk),
    .rst (reset),
    .t   (t),
    .q   (q)
  );

endmodule

// File: tb/tb_tff_count_sched.sv
// Bench for tff_count_sched: directed scenarios with literal expectations plus random
// stimulus, all checked every cycle against an arithmetic model of the counter.
module tb_tff_count_sched;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic         stop;
  logic         dir;
  logic         load;
  logic [W-1:0] load_val;
  logic [W-1:0] modulus;
  logic [W-1:0] q;
  logic         tc;
  logic         busy;
  tff_sched_pkg::state_t state_dbg;

  int   n_cmp  = 0;
  int   n_bad  = 0;
  logic chk_en = 1'b0;

  logic [W-1:0] m_q;
  logic         m_run;
  logic         m_tc;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  tff_count_sched #(
    .W       (W),
    .RST_VAL ('0)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .stop      (stop),
    .dir       (dir),
    .load      (load),
    .load_val  (load_val),
    .modulus   (modulus),
    .q         (q),
    .tc        (tc),
    .busy      (busy),
    .state_dbg (state_dbg)
  );

  // ---------------- scoreboard helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Counter rules in plain integer arithmetic, updated on every rising edge.
  always @(posedge clk or posedge reset) begin
    int meff;
    int nq;
    bit wrapped;
    if (reset) begin
      m_q   = '0;
      m_run = 1'b0;
      m_tc  = 1'b0;
    end else begin
      meff    = (modulus == 0) ? (1 << W) : int'(modulus);
      nq      = int'(m_q);
      wrapped = 1'b0;
      if (load) begin
        nq    = int'(load_val);
        m_run = 1'b0;
      end else if (!m_run) begin
        if (start && !stop) m_run = 1'b1;
      end else if (stop) begin
        m_run = 1'b0;
      end else if (dir) begin
        if (nq >= meff - 1) begin
          nq      = 0;
          wrapped = 1'b1;
        end else begin
          nq = nq + 1;
        end
      end else begin
        if (nq == 0) begin
          nq      = meff - 1;
          wrapped = 1'b1;
        end else begin
          nq = nq - 1;
        end
      end
`ifdef TFF_SCHED_AUTOSTOP_EN
      if (wrapped) m_run = 1'b0;
`endif
      m_q  = W'(nq);
      m_tc = wrapped;
    end
  end

  // Single compare process, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check("model_q", 32'(q), 32'(m_q));
      check("model_tc", 32'(tc), 32'(m_tc));
      check("model_busy", 32'(busy), 32'(m_run));
    end
  end

  // ---------------- driver ----------------
  task automatic cyc(input logic s, input logic p, input logic d, input logic l,
                     input logic [W-1:0] lv, input logic [W-1:0] m);
    start    = s;
    stop     = p;
    dir      = d;
    load     = l;
    load_val = lv;
    modulus  = m;
    @(negedge clk);
  endtask

  task automatic expect3(input string name, input int eq, input int etc, input int ebusy);
    check({name, "_q"}, 32'(q), 32'(eq));
    check({name, "_tc"}, 32'(tc), 32'(etc));
    check({name, "_busy"}, 32'(busy), 32'(ebusy));
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [W-1:0] rmod;
    reset = 1'b1;
    start = 1'b0; stop = 1'b0; dir = 1'b1; load = 1'b0;
    load_val = '0; modulus = '0;
    repeat (2) @(negedge clk);
    chk_en = 1'b1;
    expect3("reset", 0, 0, 0);
    reset = 1'b0;
    @(negedge clk);

    // Up count, modulus 10
    cyc(1, 0, 1, 0, 0, 10);
    expect3("up_start", 0, 0, 1);
    for (int i = 1; i <= 10; i++) begin
      cyc(0, 0, 1, 0, 0, 10);
      check("up_q", 32'(q), 32'(i % 10));
      check("up_tc", 32'(tc), (i == 10) ? 32'd1 : 32'd0);
    end
`ifdef TFF_SCHED_AUTOSTOP_EN
    check("autostop_busy", 32'(busy), 0);
    for (int i = 0; i < 5; i++) begin
      cyc(0, 0, 1, 0, 0, 10);
      expect3("autostop_hold", 0, 0, 0);
    end
`endif

    // Down count, modulus 10, from 0
    cyc(0, 1, 0, 0, 0, 10);
    cyc(0, 0, 0, 1, 0, 10);
    cyc(1, 0, 0, 0, 0, 10);
    expect3("dn_start", 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 10);
    check("dn_wrap_q", 32'(q), 9);
    check("dn_wrap_tc", 32'(tc), 1);
`ifndef TFF_SCHED_AUTOSTOP_EN
    cyc(0, 0, 0, 0, 0, 10);
    expect3("dn_8", 8, 0, 1);
    cyc(0, 0, 0, 0, 0, 10);
    expect3("dn_7", 7, 0, 1);
`endif

    // Full range (modulus 0)
    cyc(0, 1, 0, 0, 0, 0);
    cyc(0, 0, 1, 1, 14, 0);
    expect3("full_load", 14, 0, 0);
    cyc(1, 0, 1, 0, 0, 0);
    cyc(0, 0, 1, 0, 0, 0);
    expect3("full_15", 15, 0, 1);
    cyc(0, 0, 1, 0, 0, 0);
    check("full_wrap_q", 32'(q), 0);
    check("full_wrap_tc", 32'(tc), 1);
    cyc(0, 1, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    check("full_dn_q", 32'(q), 15);
    check("full_dn_tc", 32'(tc), 1);

    // Load beats stop; start with stop stays idle
    cyc(0, 0, 1, 1, 0, 10);
    cyc(1, 0, 1, 0, 0, 10);
    repeat (3) cyc(0, 0, 1, 0, 0, 10);
    expect3("pri_at3", 3, 0, 1);
    cyc(0, 1, 1, 1, 12, 10);
    expect3("pri_load", 12, 0, 0);
    cyc(1, 1, 1, 0, 0, 10);
    expect3("pri_startstop", 12, 0, 0);

    // Asynchronous reset mid-run
    cyc(0, 0, 1, 1, 0, 10);
    cyc(1, 0, 1, 0, 0, 10);
    repeat (7) cyc(0, 0, 1, 0, 0, 10);
    expect3("ar_at7", 7, 0, 1);
    #2 reset = 1'b1;
    #1 expect3("ar_async", 0, 0, 0);
    @(negedge clk);
    reset = 1'b0;
    repeat (2) cyc(0, 0, 1, 0, 0, 10);
    expect3("ar_idle", 0, 0, 0);

    // Modulus 1: q pinned at 0, tc every RUN cycle
    cyc(1, 0, 1, 0, 0, 1);
    cyc(0, 0, 1, 0, 0, 1);
    check("m1_q", 32'(q), 0);
    check("m1_tc", 32'(tc), 1);
`ifndef TFF_SCHED_AUTOSTOP_EN
    cyc(0, 0, 1, 0, 0, 1);
    expect3("m1_again", 0, 1, 1);
`endif

    // Randomized stimulus, checked by the model every cycle
    rmod = W'($urandom);
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 31) == 0) rmod = W'($urandom);
      if ($urandom_range(0, 999) == 0) begin
        #2 reset = 1'b1;
        #1 expect3("rand_async", 0, 0, 0);
        @(negedge clk);
        reset = 1'b0;
      end
      cyc($urandom_range(0, 3) == 0, $urandom_range(0, 15) == 0,
          1'($urandom_range(0, 1)), $urandom_range(0, 19) == 0,
          W'($urandom), rmod);
    end

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/tff_count_sched.md
Name: tff_count_sched

Overview:
Controller that sequences a bank of W T flip-flops as a programmable modulo counter by computing the per-bit toggle vector each cycle. It supports start/stop, direction, a runtime modulus, and a single-cycle parallel load implemented as a toggle mask (t = q ^ load_val). It sits between control logic and the T flip-flop register bank, and is the sole driver of every toggle input in that bank.

Parameters:
W, 4, counter/bank width in bits (W >= 2)
RST_VAL, 0, value of q after reset (W bits)

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-high; clears all state immediately
start  input  1  level; IDLE -> RUN when sampled high
stop  input  1  level; RUN -> IDLE when sampled high
dir  input  1  1 = count up, 0 = count down; sampled every cycle
load  input  1  parallel-load request; q becomes load_val on the next edge
load_val  input  W  value to load
modulus  input  W  count modulus M; 0 means 2^W
q  output  W  counter value (TFF bank outputs)
tc  output  1  terminal-count pulse, registered
busy  output  1  high while in RUN, registered

Behaviour:
- One clock domain, clk. Reset is asynchronous and active-high: q=RST_VAL, tc=0, busy=0, state=IDLE. Reset asserted mid-run takes effect immediately, without waiting for an edge.
- States: IDLE, RUN. Priority per cycle, highest first: load > stop > start > count.
- load=1 (any state): t = q ^ load_val. Next edge: q=load_val, state=IDLE, busy=0, tc=0. A value with load_val >= M is loaded as-is.
- IDLE: t = 0, so q holds. start=1 & stop=0 -> RUN. start=1 & stop=1 -> stays IDLE.
- RUN, stop=1: t = 0, so q holds; next state IDLE.
- RUN, up count:
  - Normal step: t[0]=1, t[i] = &q[i-1:0].
  - If q >= Meff-1 (Meff = M, or 2^W when M=0): t = q, so q wraps to 0.
- RUN, down count:
  - Normal step: t[0]=1, t[i] = ~|q[i-1:0].
  - If q == 0: t = q ^ (Meff-1), so q wraps to Meff-1.
  - Out-of-range q (q >= Meff) decrements normally.
- tc is set on the same edge that applies a wrap, so it is high in the cycle in which q shows the wrapped value. Otherwise tc is 0. It is a one-cycle pulse unless wraps occur back-to-back.
- M=1: q stays 0 and tc is high every RUN cycle.
- Changes to dir or modulus take effect on the next computed step. No glitching: t is combinational from registered q and the sampled inputs.
- busy = (next_state == RUN), registered.
- Latency: one edge from any request to the q update. start produces the first count step on the edge after busy rises.

Optional Feature:
TFF_SCHED_AUTOSTOP_EN.
- Defined: one-shot mode. On the edge that applies a wrap in RUN, the next state is IDLE. tc pulses, busy drops in the same cycle, and q holds the wrapped value until the next start.
- Undefined: free-running; RUN continues through wraps until stop or load.

Decomposition:
- Shared package tff_sched_pkg holds:
  - the state encoding constants (IDLE=1'b0, RUN=1'b1);
  - default W;
  - functions up_toggle(q), down_toggle(q), and eff_mod(M, W).
- One natural sub-module: tff_bank, a W-bit register of T flip-flops with per-bit toggle inputs, clk, and async active-high reset to RST_VAL. tff_count_sched instantiates it and drives only its t vector.

Test Plan:
- Up count wrap (W=4): reset, modulus=10, dir=1, start=1 -> busy=1; q=0,1,...,9,0; tc=1 only in the cycle q returns to 0.
- Down count wrap: modulus=10, dir=0, start from q=0 -> q=9,8,7; tc=1 in the cycle q=9.
- Full-range wrap: modulus=0, load_val=14, then up run -> q=14,15,0; tc at 0. Down from 0 -> 15 with tc.
- Load priority: while RUN at q=3, assert load=1, stop=1, load_val=12 -> next cycle q=12, busy=0, tc=0. With start=1 & stop=1 in IDLE, state remains IDLE.
- Async reset: assert reset mid-cycle during RUN at q=7 -> q=0, busy=0, tc=0 before the next clk edge. Release reset -> stays IDLE.
- With TFF_SCHED_AUTOSTOP_EN, modulus=3, up -> q=0,1,2,0; tc=1 and busy=0 together, then q holds 0 for 5 cycles.
